relay_fb_monitor: RTL

Reads back the relay contact-sense input and checks it against the commanded relay level produced by the relay/buzzer toggle driver. It is the receive side of that relay command path. The block does the following:
- synchronises and debounces the contact feedback;
- measures the switching latency of every commanded transition;
- flags a sticky fault on timeout or on an uncommanded contact change;
- drives an alarm toggle for the buzzer path while the fault is set.

---
 rtl/relay_pkg.sv | 22 ++
 rtl/relay_debounce.sv | 41 ++++
 rtl/relay_fb_monitor.sv | 127 ++++++++++++
 3 files changed

// File: rtl/relay_pkg.sv
// Shared types for the relay feedback monitor: FSM encoding, fault cause codes
// and a counter-width helper.
package relay_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_TMO  = 2'b01,
        CAUSE_SPUR = 2'b10
    } cause_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/relay_debounce.sv
// Two-flop synchroniser followed by a stability counter; dout only follows din
// after the synchronised level has differed for DEBOUNCE_CYC consecutive cycles.
module relay_debounce
    import relay_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic osc,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int DW = cnt_w(DEBOUNCE_CYC);

    logic [1:0]    sync;
    logic          fb_sync;
    logic [DW-1:0] deb_cnt;

    assign fb_sync = sync[1];

    always_ff @(posedge osc) begin
        if (reset) begin
            sync    <= 2'b00;
            deb_cnt <= '0;
            dout    <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            // Any return to the accepted level restarts the stability window.
            if (fb_sync == dout) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DW'(DEBOUNCE_CYC - 1)) begin
                dout    <= fb_sync;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/relay_fb_monitor.sv
// Relay contact-sense monitor: measures command-to-feedback latency, latches a
// sticky fault on timeout or uncommanded contact change, and drives the alarm.
module relay_fb_monitor
    import relay_pkg::*;
#(
    parameter int DEBOUNCE_CYC   = 500000,
    parameter int TIMEOUT_CYC    = 2500000,
    parameter int ALARM_HALF_CYC = 12500000,
    parameter int LAT_W          = 22
) (
    input  logic             osc,
    input  logic             reset,
    input  logic             relay_cmd,
    input  logic             fb_in,
    input  logic             fault_clr,
    output logic             fb_clean,
    output logic [LAT_W-1:0] lat_cyc,
    output logic             lat_valid,
    output logic             fault,
    output logic [1:0]       fault_cause,
    output logic             alarm_tgl
);

    localparam int AW = cnt_w(ALARM_HALF_CYC);

    logic             cmd_q;
    logic             cmd_edge;
    state_t           state, state_nx;
    cause_t           cause, cause_nx;
    logic [LAT_W-1:0] timer, timer_nx;
    logic [LAT_W-1:0] lat_q, lat_nx;
    logic             lat_vld, lat_vld_nx;
    logic             alarm, alarm_nx;
    logic [AW-1:0]    acnt, acnt_nx;

    relay_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_deb (
        .osc  (osc),
        .reset(reset),
        .din  (fb_in),
        .dout (fb_clean)
    );

    assign cmd_edge = relay_cmd ^ cmd_q;

    always_ff @(posedge osc) begin
        if (reset) begin
            cmd_q   <= 1'b0;
            state   <= IDLE;
            cause   <= CAUSE_NONE;
            timer   <= '0;
            lat_q   <= '0;
            lat_vld <= 1'b0;
            alarm   <= 1'b0;
            acnt    <= '0;
        end else begin
            cmd_q   <= relay_cmd;
            state   <= state_nx;
            cause   <= cause_nx;
            timer   <= timer_nx;
            lat_q   <= lat_nx;
            lat_vld <= lat_vld_nx;
            alarm   <= alarm_nx;
            acnt    <= acnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cause_nx   = cause;
        timer_nx   = '0;
        lat_nx     = lat_q;
        lat_vld_nx = 1'b0;
        alarm_nx   = 1'b0;
        acnt_nx    = '0;
        case (state)
            IDLE: begin
                cause_nx = CAUSE_NONE;
                if (cmd_edge) begin
                    state_nx = WAIT;
                end else if (fb_clean != cmd_q) begin
                    state_nx = FAULT;
                    cause_nx = CAUSE_SPUR;
                end
            end
            WAIT: begin
                cause_nx = CAUSE_NONE;
                // A re-command abandons the running measurement without a strobe.
                if (cmd_edge) begin
                    state_nx = WAIT;
                end else if (fb_clean == cmd_q) begin
                    lat_nx     = timer;
                    lat_vld_nx = 1'b1;
                    state_nx   = IDLE;
                end else if (timer == LAT_W'(TIMEOUT_CYC - 1)) begin
                    state_nx = FAULT;
                    cause_nx = CAUSE_TMO;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    state_nx = IDLE;
                    cause_nx = CAUSE_NONE;
                end else if (acnt == AW'(ALARM_HALF_CYC - 1)) begin
                    alarm_nx = ~alarm;
                end else begin
                    alarm_nx = alarm;
                    acnt_nx  = acnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cause_nx = CAUSE_NONE;
            end
        endcase
    end

    assign fault       = (state == FAULT);
    assign fault_cause = cause;
    assign alarm_tgl   = alarm;
    assign lat_cyc     = lat_q;
    assign lat_valid   = lat_vld;

endmodule
